// File: rtl/text_console_core.sv
// Console text store and line editor.
// Holds ROWS x COLS ASCII cells in a circular row buffer (scrolling moves the
// top-row pointer and clears one row), edits one input line with a cursor,
// streams the entered line to the host and prints host text. The renderer
// reads cells through an independent registered read port.
module text_console_core #(
  parameter int COLS       = 70,
  parameter int ROWS       = 30,
  parameter int PROMPT_LEN = 9,
  parameter int MAX_LINE   = 32,
  localparam int RW = $clog2(ROWS),
  localparam int CW = $clog2(COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_valid,
  input  logic [2:0]    key_kind,
  input  logic [7:0]    key_ascii,
  output logic          key_drop,
  output logic          busy,
  output logic          line_out_valid,
  output logic [7:0]    line_out_data,
  output logic          line_out_last,
  input  logic          line_out_ready,
  input  logic          host_valid,
  input  logic [7:0]    host_data,
  output logic          host_ready,
  input  logic          host_done,
  input  logic [RW-1:0] rd_row,
  input  logic [CW-1:0] rd_col,
  output logic [7:0]    rd_char,
  output logic          rd_cursor,
  output logic          rd_prompt
);

  localparam int CELLS = ROWS * COLS;
  localparam int AW    = $clog2(CELLS);
  localparam int LW    = $clog2(MAX_LINE + 1);
  localparam int BW    = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;

  localparam logic [2:0] ST_INIT   = 3'd0;
  localparam logic [2:0] ST_EDIT   = 3'd1;
  localparam logic [2:0] ST_SEND   = 3'd2;
  localparam logic [2:0] ST_HOST   = 3'd3;
  localparam logic [2:0] ST_SCROLL = 3'd4;

  // Where a scroll returns to; RET_DONE finishes a host_done (prompt + EDIT).
  localparam logic [1:0] RET_SEND = 2'd0;
  localparam logic [1:0] RET_HOST = 2'd1;
  localparam logic [1:0] RET_DONE = 2'd2;

  localparam logic [2:0] K_CHAR  = 3'd0;
  localparam logic [2:0] K_ENTER = 3'd1;
  localparam logic [2:0] K_BKSP  = 3'd2;
  localparam logic [2:0] K_LEFT  = 3'd3;
  localparam logic [2:0] K_RIGHT = 3'd4;

  // Logical row -> physical row of the circular buffer.
  function automatic logic [RW-1:0] phys_row(input logic [RW-1:0] top, input logic [RW-1:0] r);
    logic [RW:0] s;
    s = {1'b0, top} + {1'b0, r};
    if (s >= (RW+1)'(ROWS)) s = s - (RW+1)'(ROWS);
    return s[RW-1:0];
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] prow, input logic [CW-1:0] col);
    return AW'(prow) * AW'(COLS) + AW'(col);
  endfunction

  logic [2:0]    state_q, state_d;
  logic [1:0]    ret_q, ret_d;
  logic [RW-1:0] top_q, top_d;
  logic [RW-1:0] cur_row_q, cur_row_d;
  logic [CW-1:0] cur_col_q, cur_col_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [LW-1:0] len_q, len_d;
  logic [ROWS-1:0] prompt_q, prompt_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] clr_row_q, clr_row_d;
  logic          done_pend_q, done_pend_d;
  logic          key_drop_q;

  logic [7:0]    mem [CELLS];
  logic [7:0]    line_buf [MAX_LINE];

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic          buf_we;
  logic          nl_req;
  logic [1:0]    nl_ret;
  logic          host_acc;
  logic [RW-1:0] cur_prow, nxt_prow;
  logic [AW-1:0] cur_addr;

  logic          rd_ok;
  logic [RW-1:0] rd_prow;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data_q;
  logic          rd_ok_q, rd_cursor_q, rd_prompt_q;

  assign cur_prow = phys_row(top_q, cur_row_q);
  assign nxt_prow = phys_row(top_q, cur_row_q + 1'b1);
  assign cur_addr = cell_addr(cur_prow, cur_col_q);

  assign busy           = (state_q != ST_EDIT);
  assign host_ready     = (state_q == ST_HOST) && !done_pend_q;
  assign key_drop       = key_drop_q;
  assign line_out_valid = (state_q == ST_SEND);
  assign line_out_data  = (len_q == '0) ? 8'h00 : line_buf[idx_q[BW-1:0]];
  assign line_out_last  = (len_q == '0) || (idx_q == len_q - 1'b1);

  // Next-state logic for the editor/host FSM and the single core write port.
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    top_d       = top_q;
    cur_row_d   = cur_row_q;
    cur_col_d   = cur_col_q;
    idx_d       = idx_q;
    len_d       = len_q;
    prompt_d    = prompt_q;
    cnt_d       = cnt_q;
    clr_row_d   = clr_row_q;
    done_pend_d = done_pend_q;
    mem_we      = 1'b0;
    mem_waddr   = cur_addr;
    mem_wdata   = 8'h00;
    buf_we      = 1'b0;
    nl_req      = 1'b0;
    nl_ret      = RET_SEND;
    host_acc    = 1'b0;

    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        if (cnt_q == AW'(CELLS - 1)) begin
          cnt_d   = '0;
          state_d = ST_EDIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_EDIT: begin
        if (key_valid) begin
          case (key_kind)
            K_CHAR: begin
              if (idx_q < LW'(MAX_LINE)) begin
                buf_we    = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = key_ascii;
                idx_d     = idx_q + 1'b1;
                if (idx_q >= len_q) len_d = idx_q + 1'b1;
                cur_col_d = cur_col_q + 1'b1;
              end
            end
            K_BKSP: begin
              // Only deleting at the end of the line is supported.
              if (idx_q == len_q && len_q != '0) begin
                mem_we    = 1'b1;
                mem_waddr = cell_addr(cur_prow, cur_col_q - 1'b1);
                idx_d     = idx_q - 1'b1;
                len_d     = len_q - 1'b1;
                cur_col_d = cur_col_q - 1'b1;
              end
            end
            K_LEFT: begin
              if (idx_q != '0) begin
                idx_d     = idx_q - 1'b1;
                cur_col_d = cur_col_q - 1'b1;
              end
            end
            K_RIGHT: begin
              if (idx_q < len_q) begin
                idx_d     = idx_q + 1'b1;
                cur_col_d = cur_col_q + 1'b1;
              end
            end
            K_ENTER: begin
              // idx doubles as the send pointer from here on.
              idx_d  = '0;
              nl_req = 1'b1;
              nl_ret = RET_SEND;
            end
            default: ;
          endcase
        end
      end

      ST_SEND: begin
        if (line_out_ready) begin
          if (line_out_last) begin
            idx_d   = '0;
            len_d   = '0;
            state_d = ST_HOST;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      ST_HOST: begin
        host_acc = host_valid && !done_pend_q;
        if (host_acc && host_data == 8'h0A) begin
          nl_req = 1'b1;
          nl_ret = RET_HOST;
        end else if (host_acc && host_data != 8'h00) begin
          mem_we    = 1'b1;
          mem_wdata = host_data;
          if (cur_col_q == CW'(COLS - 1)) begin
            nl_req = 1'b1;
            nl_ret = RET_HOST;
          end else begin
            cur_col_d = cur_col_q + 1'b1;
          end
        end
        // A done arriving with a byte is deferred so the byte lands first.
        if (host_acc && host_done) begin
          done_pend_d = 1'b1;
        end else if (!host_acc && (host_done || done_pend_q)) begin
          done_pend_d = 1'b0;
          if (cur_col_q != '0) begin
            nl_req = 1'b1;
            nl_ret = RET_DONE;
          end else begin
            prompt_d[cur_prow] = 1'b1;
            cur_col_d          = CW'(PROMPT_LEN);
            state_d            = ST_EDIT;
          end
        end
      end

      ST_SCROLL: begin
        mem_we    = 1'b1;
        mem_waddr = cell_addr(clr_row_q, cnt_q[CW-1:0]);
        if (cnt_q == AW'(COLS - 1)) begin
          cnt_d = '0;
          case (ret_q)
            RET_SEND: state_d = ST_SEND;
            RET_HOST: state_d = ST_HOST;
            default: begin
              // The cleared row is now the bottom row, where the prompt goes.
              prompt_d[clr_row_q] = 1'b1;
              cur_col_d           = CW'(PROMPT_LEN);
              state_d             = ST_EDIT;
            end
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = ST_INIT;
    endcase

    if (nl_req) begin
      cur_col_d = '0;
      if (cur_row_q < RW'(ROWS - 1)) begin
        cur_row_d = cur_row_q + 1'b1;
        case (nl_ret)
          RET_SEND: state_d = ST_SEND;
          RET_HOST: state_d = ST_HOST;
          default: begin
            prompt_d[nxt_prow] = 1'b1;
            cur_col_d          = CW'(PROMPT_LEN);
            state_d            = ST_EDIT;
          end
        endcase
      end else begin
        // The old top physical row becomes the new, blank bottom row.
        top_d            = (top_q == RW'(ROWS - 1)) ? '0 : top_q + 1'b1;
        clr_row_d        = top_q;
        prompt_d[top_q]  = 1'b0;
        cnt_d            = '0;
        ret_d            = nl_ret;
        state_d          = ST_SCROLL;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      ret_q       <= RET_SEND;
      top_q       <= '0;
      cur_row_q   <= '0;
      cur_col_q   <= CW'(PROMPT_LEN);
      idx_q       <= '0;
      len_q       <= '0;
      prompt_q    <= ROWS'(1);
      cnt_q       <= '0;
      clr_row_q   <= '0;
      done_pend_q <= 1'b0;
      key_drop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      top_q       <= top_d;
      cur_row_q   <= cur_row_d;
      cur_col_q   <= cur_col_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      prompt_q    <= prompt_d;
      cnt_q       <= cnt_d;
      clr_row_q   <= clr_row_d;
      done_pend_q <= done_pend_d;
      key_drop_q  <= key_valid && (state_q != ST_EDIT);
    end
  end

  // Line buffer holding the bytes being edited.
  always_ff @(posedge clk) begin
    if (buf_we) line_buf[idx_q[BW-1:0]] <= key_ascii;
  end

  assign rd_ok   = ({1'b0, rd_row} < (RW+1)'(ROWS)) && ({1'b0, rd_col} < (CW+1)'(COLS));
  assign rd_prow = phys_row(top_q, rd_row);
  assign rd_addr = rd_ok ? cell_addr(rd_prow, rd_col) : '0;

  // Screen memory: core write port plus registered renderer read port.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    rd_data_q <= mem[rd_addr];
  end

  // Renderer flags aligned with the one-cycle memory read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ok_q     <= 1'b0;
      rd_cursor_q <= 1'b0;
      rd_prompt_q <= 1'b0;
    end else begin
      rd_ok_q     <= rd_ok;
      rd_cursor_q <= rd_ok && (state_q == ST_EDIT) && (rd_row == cur_row_q) && (rd_col == cur_col_q);
      rd_prompt_q <= rd_ok && prompt_q[rd_prow] && ({1'b0, rd_col} < (CW+1)'(PROMPT_LEN));
    end
  end

  assign rd_char   = rd_ok_q ? rd_data_q : 8'h00;
  assign rd_cursor = rd_cursor_q;
  assign rd_prompt = rd_prompt_q;

endmodule

// File: tb/tb_text_console_core.sv
// Directed bench for text_console_core with default parameters.
module tb_text_console_core;
  localparam int COLS = 70;
  localparam int ROWS = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [2:0] key_kind = 3'd0;
  logic [7:0] key_ascii = 8'h00;
  logic       key_drop, busy;
  logic       line_out_valid, line_out_last;
  logic [7:0] line_out_data;
  logic       line_out_ready = 1'b0;
  logic       host_valid = 1'b0;
  logic [7:0] host_data = 8'h00;
  logic       host_ready;
  logic       host_done = 1'b0;
  logic [4:0] rd_row = 5'd0;
  logic [6:0] rd_col = 7'd0;
  logic [7:0] rd_char;
  logic       rd_cursor, rd_prompt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  text_console_core #(.COLS(COLS), .ROWS(ROWS), .PROMPT_LEN(9), .MAX_LINE(32)) dut (
    .clk(clk), .rst(rst),
    .key_valid(key_valid), .key_kind(key_kind), .key_ascii(key_ascii), .key_drop(key_drop),
    .busy(busy),
    .line_out_valid(line_out_valid), .line_out_data(line_out_data), .line_out_last(line_out_last),
    .line_out_ready(line_out_ready),
    .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready), .host_done(host_done),
    .rd_row(rd_row), .rd_col(rd_col), .rd_char(rd_char), .rd_cursor(rd_cursor), .rd_prompt(rd_prompt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cell(input string tag, input int r, input int c,
                            input logic [7:0] ech, input logic ecu, input logic epr);
    rd_row = 5'(r);
    rd_col = 7'(c);
    tick();
    chk({tag, ".char"}, 32'(rd_char), 32'(ech));
    chk({tag, ".cursor"}, 32'(rd_cursor), 32'(ecu));
    chk({tag, ".prompt"}, 32'(rd_prompt), 32'(epr));
    $display("cell %s (%0d,%0d): char=%02h cursor=%0d prompt=%0d", tag, r, c, rd_char, rd_cursor, rd_prompt);
  endtask

  task automatic send_key(input logic [2:0] kind, input logic [7:0] ascii);
    key_valid = 1'b1;
    key_kind  = kind;
    key_ascii = ascii;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, output int n);
    n = 0;
    while (busy && n < 5000) begin
      tick();
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic get_beat(input string tag, input logic [7:0] ed, input logic el);
    int n;
    n = 0;
    while (!line_out_valid && n < 200) begin
      tick();
      n++;
    end
    chk({tag, ".valid"}, 32'(line_out_valid), 32'd1);
    chk({tag, ".data"}, 32'(line_out_data), 32'(ed));
    chk({tag, ".last"}, 32'(line_out_last), 32'(el));
    $display("beat %s: data=%02h last=%0d", tag, line_out_data, line_out_last);
    tick();
  endtask

  task automatic host_send(input logic [7:0] d, input logic done);
    int n;
    host_valid = 1'b1;
    host_data  = d;
    n = 0;
    while (!host_ready && n < 200) begin
      tick();
      n++;
    end
    if (!host_ready) chk("host_ready_wait", 32'(host_ready), 32'd1);
    host_done = done;
    tick();
    host_valid = 1'b0;
    host_done  = 1'b0;
  endtask

  task automatic done_pulse();
    host_done = 1'b1;
    tick();
    host_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // 1: reset state, INIT length, empty screen with prompt on row 0
    repeat (3) tick();
    chk("rst.line_out_valid", 32'(line_out_valid), 32'd0);
    chk("rst.key_drop", 32'(key_drop), 32'd0);
    chk("rst.host_ready", 32'(host_ready), 32'd0);
    chk("rst.rd_char", 32'(rd_char), 32'd0);
    chk("rst.rd_cursor", 32'(rd_cursor), 32'd0);
    chk("rst.rd_prompt", 32'(rd_prompt), 32'd0);
    rst = 1'b0;
    wait_idle("init.idle", n);
    chk("init.cycles", 32'(n), 32'(ROWS * COLS));
    $display("init done after %0d cycles", n);
    check_cell("i00", 0, 0, 8'h00, 1'b0, 1'b1);
    check_cell("i08", 0, 8, 8'h00, 1'b0, 1'b1);
    check_cell("i09", 0, 9, 8'h00, 1'b1, 1'b0);
    check_cell("i10", 1, 0, 8'h00, 1'b0, 1'b0);
    check_cell("ilast", 29, 69, 8'h00, 1'b0, 1'b0);
    check_cell("ioor_row", 30, 0, 8'h00, 1'b0, 1'b0);
    check_cell("ioor_col", 0, 70, 8'h00, 1'b0, 1'b0);

    // 2: "ls", left, left, "c" -> line "cs"
    send_key(3'd0, "l");
    send_key(3'd0, "s");
    send_key(3'd3, 8'h00);
    send_key(3'd3, 8'h00);
    send_key(3'd0, "c");
    check_cell("e09", 0, 9, "c", 1'b0, 1'b1 & 1'b0);
    check_cell("e10", 0, 10, "s", 1'b1, 1'b0);
    check_cell("e11", 0, 11, 8'h00, 1'b0, 1'b0);
    send_key(3'd1, 8'h00);
    chk("send.hold0.valid", 32'(line_out_valid), 32'd1);
    chk("send.hold0.data", 32'(line_out_data), 32'("c"));
    chk("send.hold0.last", 32'(line_out_last), 32'd0);
    tick();
    tick();
    chk("send.hold2.valid", 32'(line_out_valid), 32'd1);
    chk("send.hold2.data", 32'(line_out_data), 32'("c"));
    line_out_ready = 1'b1;
    get_beat("cs0", "c", 1'b0);
    get_beat("cs1", "s", 1'b1);
    chk("send.after.valid", 32'(line_out_valid), 32'd0);
    chk("host.ready", 32'(host_ready), 32'd1);
    done_pulse();
    chk("done1.busy", 32'(busy), 32'd0);
    check_cell("d1p", 1, 0, 8'h00, 1'b0, 1'b1);
    check_cell("d1c", 1, 9, 8'h00, 1'b1, 1'b0);
    check_cell("d1old", 0, 9, "c", 1'b0, 1'b0);

    // 3: enter on an empty line -> one 0x00 beat
    send_key(3'd1, 8'h00);
    get_beat("empty", 8'h00, 1'b1);
    chk("host.ready2", 32'(host_ready), 32'd1);
    done_pulse();
    check_cell("d2p", 2, 0, 8'h00, 1'b0, 1'b1);
    check_cell("d2c", 2, 9, 8'h00, 1'b1, 1'b0);

    // 4: 75 host bytes wrap at column 69, done on the last byte
    send_key(3'd1, 8'h00);
    get_beat("empty4", 8'h00, 1'b1);
    for (int i = 0; i < 75; i++) host_send("A", i == 74);
    wait_idle("wrap.idle", n);
    check_cell("w30", 3, 0, "A", 1'b0, 1'b0);
    check_cell("w369", 3, 69, "A", 1'b0, 1'b0);
    check_cell("w44", 4, 4, "A", 1'b0, 1'b0);
    check_cell("w45", 4, 5, 8'h00, 1'b0, 1'b0);
    check_cell("w5p", 5, 0, 8'h00, 1'b0, 1'b1);
    check_cell("w5c", 5, 9, 8'h00, 1'b1, 1'b0);

    // 5: newlines down to the last row, then one more scrolls
    send_key(3'd1, 8'h00);
    get_beat("empty5", 8'h00, 1'b1);
    for (int i = 0; i < 23; i++) host_send(8'h0A, 1'b0);
    host_send(8'h0A, 1'b0);
    n = 0;
    while (!host_ready && n < 200) begin
      tick();
      n++;
    end
    chk("scroll.cycles", 32'(n), 32'(COLS));
    $display("scroll held host_ready low for %0d cycles", n);
    check_cell("s0p", 0, 0, 8'h00, 1'b0, 1'b1);
    check_cell("s1p", 1, 0, 8'h00, 1'b0, 1'b1);
    check_cell("s20", 2, 0, "A", 1'b0, 1'b0);
    check_cell("s34", 3, 4, "A", 1'b0, 1'b0);
    check_cell("s4p", 4, 0, 8'h00, 1'b0, 1'b1);
    check_cell("s29_0", 29, 0, 8'h00, 1'b0, 1'b0);
    check_cell("s29_9", 29, 9, 8'h00, 1'b0, 1'b0);
    check_cell("s29_10", 29, 10, 8'h00, 1'b0, 1'b0);

    // 6: max line length, backspace at end, key drop in SEND, reset mid-SEND
    done_pulse();
    wait_idle("d6.idle", n);
    check_cell("d6p", 29, 0, 8'h00, 1'b0, 1'b1);
    check_cell("d6c", 29, 9, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 32; i++) send_key(3'd0, 8'(97 + (i % 26)));
    send_key(3'd0, "Z");
    check_cell("m9", 29, 9, "a", 1'b0, 1'b0);
    check_cell("m40", 29, 40, "f", 1'b0, 1'b0);
    check_cell("m41", 29, 41, 8'h00, 1'b1, 1'b0);
    send_key(3'd2, 8'h00);
    check_cell("bs40", 29, 40, 8'h00, 1'b1, 1'b0);
    send_key(3'd0, "F");
    check_cell("re40", 29, 40, "F", 1'b0, 1'b0);
    line_out_ready = 1'b0;
    send_key(3'd1, 8'h00);
    n = 0;
    while (!line_out_valid && n < 200) begin
      tick();
      n++;
    end
    chk("s6.valid", 32'(line_out_valid), 32'd1);
    chk("s6.data", 32'(line_out_data), 32'("a"));
    chk("s6.last", 32'(line_out_last), 32'd0);
    chk("drop.before", 32'(key_drop), 32'd0);
    send_key(3'd0, "q");
    chk("drop.pulse", 32'(key_drop), 32'd1);
    tick();
    chk("drop.after", 32'(key_drop), 32'd0);
    chk("drop.data_kept", 32'(line_out_data), 32'("a"));
    chk("drop.valid_kept", 32'(line_out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst2.valid", 32'(line_out_valid), 32'd0);
    chk("rst2.host_ready", 32'(host_ready), 32'd0);
    chk("rst2.busy", 32'(busy), 32'd1);
    tick();
    tick();
    rst = 1'b0;
    wait_idle("rst2.idle", n);
    chk("rst2.cycles", 32'(n), 32'(ROWS * COLS));
    check_cell("r00", 0, 0, 8'h00, 1'b0, 1'b1);
    check_cell("r09", 0, 9, 8'h00, 1'b1, 1'b0);
    check_cell("r30", 3, 0, 8'h00, 1'b0, 1'b0);
    check_cell("r50", 5, 0, 8'h00, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
